cache_fill_fsm: RTL
===================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL: miss_detected  input  1  cache lookup missed this cycle; request for a line fill.
REQ-004 SHALL: miss_address  input  16  byte address of missed access; sampled when a fill starts.
REQ-005 SHALL: fsm_busy  output  1  pipeline stall request while a fill is pending or active.
REQ-006 SHALL: memory_read_en  output  1  one read request to main memory this cycle.
REQ-007 SHALL: memory_address  output  16  word-aligned byte address of the current read request.
REQ-008 SHALL: memory_data_valid  input  1  main memory returns one word this cycle.
REQ-009 SHALL: memory_data  input  16  returned word; valid only with memory_data_valid.
REQ-010 SHALL: write_data_array  output  1  write fill_data into the cache data array at fill_word_offset.
REQ-011 SHALL: fill_word_offset  output  3  word index (0-7) within the line for the current data write.
REQ-012 SHALL: fill_data  output  16  word to write; equals memory_data.
REQ-013 SHALL: write_tag_array  output  1  one-cycle pulse writing tag and valid bit for the filled line.
REQ-014 SHALL: fill_base_address  output  16  captured line base (miss_address & 16'hFFF0), held from fill start until the next fill starts.

Function
REQ-015 SHALL: line = 16 bytes = 8 words; main memory is pipelined with a fixed 4-cycle latency (request at cycle t returns at t+4).
REQ-016 SHALL: two states, IDLE and FILL; reset state IDLE.
REQ-017 SHALL: IDLE with miss_detected=1: fsm_busy=1 combinationally in that cycle, capture base and start order, move to FILL next edge.
REQ-018 SHALL: FILL: issue counter 0..7; memory_read_en=1 for exactly 8 consecutive cycles starting in the first FILL cycle; memory_address = base + 2*word index of request.
REQ-019 SHALL: issue counter saturates at 8; memory_read_en=0 once all 8 are issued.
REQ-020 SHALL: receive counter 0..7 increments only on memory_data_valid in FILL; each such cycle write_data_array=1, fill_word_offset = word index of that return, fill_data = memory_data.
REQ-021 SHALL: on 8th valid return: write_data_array=1 and write_tag_array=1 in the same cycle; next state IDLE; counters cleared.
REQ-022 SHALL: fsm_busy=1 for every FILL cycle, including the 8th-return cycle; 0 in IDLE unless REQ-017 applies.
REQ-023 SHALL: nominal timing, miss at cycle 0: requests cycles 1-8, returns 5-12, tag write 12, fsm_busy=0 at cycle 13 (busy 13 cycles total).
REQ-024 SHALL: miss_detected in FILL ignored; miss_address not re-sampled.
REQ-025 SHALL: memory_data_valid in IDLE ignored; no array writes.
REQ-026 SHALL: memory_data_valid stalls (gaps) tolerated; fill completes only after 8 returns, however spaced.
REQ-027 SHALL: miss in IDLE the cycle after a fill completes starts a new fill (back-to-back allowed).
REQ-028 SHALL: address arithmetic is 16-bit; base 16'hFFF0 yields requests up to 16'hFFFE, no carry out of the line.

Reset
REQ-029 SHALL: rst=1: next state IDLE, counters 0, fill_base_address 16'h0000.
REQ-030 SHALL: while rst=1 and the cycle after, outputs fsm_busy, memory_read_en, write_data_array and write_tag_array =0; memory_address, fill_word_offset and fill_data =0.
REQ-031 SHALL: reset mid-fill abandons the fill with no tag write; main memory shares rst and discards outstanding requests.

Configuration
REQ-032 SHALL: macro CACHE_FILL_CRITICAL_WORD_FIRST_EN defined: first request and first return are word miss_address[3:1]; subsequent words are index+1 mod 8.
REQ-033 SHALL: macro undefined: request and return order is word 0..7 regardless of miss_address.
REQ-034 SHALL: tag write on the 8th return and all timing are identical in both builds.

Verification
REQ-035 SHALL: reset, miss at 16'h1234 -> reads 16'h1230..16'h123E cycles 1-8; writes at offsets 0-7; tag pulse cycle 12; busy low cycle 13.
REQ-036 SHALL: CACHE_FILL_CRITICAL_WORD_FIRST_EN, miss 16'h123A -> addresses 16'h123A, 123C, 123E, 1230..1238; offsets 5,6,7,0..4.
REQ-037 SHALL: valid withheld 3 cycles after the 4th return -> tag pulse delayed 3 cycles to cycle 15; busy held through.
REQ-038 SHALL: rst at cycle 6 of a fill -> no write_tag_array pulse; cycle 8 outputs all 0; new miss at 16'h0040 then fills normally.
REQ-039 SHALL: miss at 16'hFFF2, with a second miss held high throughout the fill -> addresses end at 16'hFFFE; second fill starts the cycle after the first ends.
REQ-040 SHALL: memory_data_valid pulses in IDLE -> write_data_array stays 0.

Source files
------------

// File: rtl/cache_fill_fsm_if.sv
// Cache line fill bus bundle.
//
// Groups the miss request, main-memory read/return and cache-array write signals
// used by cache_fill_fsm.
//   master : the surrounding pipeline / memory side (drives miss and memory returns)
//   slave  : the fill controller (drives stall, memory reads and array writes)
//
// Signals:
//   miss_detected      cache lookup missed; request a line fill
//   miss_address[15:0] byte address of the missed access
//   fsm_busy           pipeline stall while a fill is pending or active
//   memory_read_en     one read request to main memory this cycle
//   memory_address     word-aligned byte address of the read request
//   memory_data_valid  main memory returns one word this cycle
//   memory_data[15:0]  returned word
//   write_data_array   write fill_data into the data array at fill_word_offset
//   fill_word_offset   word index (0-7) within the line
//   fill_data[15:0]    word to write
//   write_tag_array    one-cycle tag/valid write for the filled line
//   fill_base_address  captured line base address
interface cache_fill_fsm_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic [2:0]  fill_word_offset;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [15:0] fill_base_address;

  modport master (
    output miss_detected,
    output miss_address,
    output memory_data_valid,
    output memory_data,
    input  fsm_busy,
    input  memory_read_en,
    input  memory_address,
    input  write_data_array,
    input  fill_word_offset,
    input  fill_data,
    input  write_tag_array,
    input  fill_base_address
  );

  modport slave (
    input  miss_detected,
    input  miss_address,
    input  memory_data_valid,
    input  memory_data,
    output fsm_busy,
    output memory_read_en,
    output memory_address,
    output write_data_array,
    output fill_word_offset,
    output fill_data,
    output write_tag_array,
    output fill_base_address
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache line fill controller.
//
// On a miss in IDLE, captures the 16-byte line base and moves to FILL, where it issues
// eight consecutive word reads to a pipelined main memory (fixed 4-cycle latency) and
// writes each returned word into the data array. The eighth return also writes the tag.
//
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  cache_fill_fsm_if.slave (miss request, memory read/return, array writes)
//
// Build option:
//   CACHE_FILL_CRITICAL_WORD_FIRST_EN  when defined, requests and returns start at word
//   miss_address[3:1] and wrap mod 8; otherwise the order is always word 0..7.
module cache_fill_fsm (
  input logic             clk,
  input logic             rst,
  cache_fill_fsm_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e      state_q, state_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;  // saturates at 8
  logic [2:0]  recv_cnt_q, recv_cnt_d;
  logic [15:0] base_q, base_d;
  logic        rst_q;                     // high in the cycle after reset
  logic [2:0]  start_word;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [2:0]  start_word_q, start_word_d;
  assign start_word = start_word_q;
`else
  assign start_word = 3'd0;
`endif

  logic        start_fill;
  logic        fill_active;
  logic        issue_en;
  logic        ret_en;
  logic        last_ret;
  logic [2:0]  issue_word;
  logic [2:0]  ret_word;

  // Outputs are forced quiet during reset and the cycle after it.
  assign start_fill  = (state_q == StIdle) && bus.miss_detected && !rst && !rst_q;
  assign fill_active = (state_q == StFill) && !rst;
  assign issue_en    = fill_active && !issue_cnt_q[3];
  assign ret_en      = fill_active && bus.memory_data_valid;
  assign last_ret    = ret_en && (recv_cnt_q == 3'd7);
  // 3-bit sums wrap within the line, so no carry reaches the tag bits.
  assign issue_word  = start_word + issue_cnt_q[2:0];
  assign ret_word    = start_word + recv_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 3'd0;
      base_q      <= 16'h0000;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      start_word_q <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      start_word_q <= start_word_d;
`endif
    end
    rst_q <= rst;
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    base_d      = base_q;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    start_word_d = start_word_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_fill) begin
          state_d     = StFill;
          base_d      = bus.miss_address & 16'hFFF0;
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 3'd0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
          start_word_d = bus.miss_address[3:1];
`endif
        end
      end
      StFill: begin
        if (issue_en) issue_cnt_d = issue_cnt_q + 4'd1;
        if (ret_en)   recv_cnt_d  = recv_cnt_q + 3'd1;
        if (last_ret) begin
          state_d     = StIdle;
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 3'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.fsm_busy          = start_fill || fill_active;
    bus.memory_read_en    = issue_en;
    bus.memory_address    = 16'h0000;
    bus.write_data_array  = ret_en;
    bus.fill_word_offset  = 3'd0;
    bus.fill_data         = 16'h0000;
    bus.write_tag_array   = last_ret;
    bus.fill_base_address = base_q;
    if (issue_en) bus.memory_address = {base_q[15:4], issue_word, 1'b0};
    if (ret_en) begin
      bus.fill_word_offset = ret_word;
      bus.fill_data        = bus.memory_data;
    end
  end

endmodule
